// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//   Parallel-to-serial front end for the single-bit sequence detectors.
//   Takes WIDTH-bit words over valid/ready and shifts out one bit per
//   bit_en cycle. Back-to-back words are seamless, so a pattern can span a
//   word boundary. With no data, bit_out sits at IDLE_LEVEL and bit_valid=0.
//
//   Optional feature: define SERIALIZER_PARITY_EN to append one even-parity
//   bit (XOR of the word) after the last data bit. A frame is then WIDTH+1
//   bits long.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   din          parallel word
//   din_valid    din holds a word
//   din_ready    word accepted this cycle (combinational)
//   bit_en       pacing strobe; one bit advances per cycle with bit_en=1
//   bit_out      serial bit (registered)
//   bit_valid    bit_out carries data (registered)
//   frame_start  first bit of a word is on bit_out (registered)
//   frame_end    last bit of a frame is on bit_out (registered)
//   busy         state != IDLE
module seq_bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] shift, shift_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             xfer;
   logic             bit_out_n, bit_valid_n, frame_start_n, frame_end_n;
`ifdef SERIALIZER_PARITY_EN
   logic             par, par_n;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shift       <= '0;
         cnt         <= '0;
         bit_out     <= IDLE_LEVEL;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par         <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         shift       <= shift_n;
         cnt         <= cnt_n;
         bit_out     <= bit_out_n;
         bit_valid   <= bit_valid_n;
         frame_start <= frame_start_n;
         frame_end   <= frame_end_n;
`ifdef SERIALIZER_PARITY_EN
         par         <= par_n;
`endif
      end
   end

   assign busy = (state != IDLE);

   // Ready only where the next edge frees the shifter: idle, or the last
   // serial bit of the frame is being consumed this cycle.
   always_comb begin
      din_ready = 1'b0;
      case (state)
         IDLE:    din_ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
         SHIFT:   din_ready = 1'b0;
         PAR:     din_ready = bit_en;
`else
         SHIFT:   din_ready = bit_en && (cnt == LAST);
`endif
         default: din_ready = 1'b0;
      endcase
   end

   assign xfer = din_valid && din_ready;

   // Next-state logic. The registered outputs are derived from the next
   // state so they line up with the shifter without a combinational path
   // from din to bit_out.
   always_comb begin
      state_n = state;
      shift_n = shift;
      cnt_n   = cnt;
`ifdef SERIALIZER_PARITY_EN
      par_n   = par;
`endif
      if (xfer) begin
         state_n = SHIFT;
         shift_n = din;
         cnt_n   = '0;
`ifdef SERIALIZER_PARITY_EN
         par_n   = ^din;
`endif
      end else begin
         case (state)
            IDLE: ;
            SHIFT: begin
               if (bit_en) begin
                  if (cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                     state_n = PAR;
`else
                     state_n = IDLE;
`endif
                  end else begin
                     shift_n = MSB_FIRST ? {shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, shift[WIDTH-1:1]};
                     cnt_n   = cnt + 1'b1;
                  end
               end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: if (bit_en) state_n = IDLE;
`endif
            default: state_n = IDLE;
         endcase
      end

      bit_out_n     = IDLE_LEVEL;
      bit_valid_n   = 1'b0;
      frame_start_n = 1'b0;
      frame_end_n   = 1'b0;
      case (state_n)
         SHIFT: begin
            bit_out_n     = MSB_FIRST ? shift_n[WIDTH-1] : shift_n[0];
            bit_valid_n   = 1'b1;
            frame_start_n = (cnt_n == '0);
`ifndef SERIALIZER_PARITY_EN
            frame_end_n   = (cnt_n == LAST);
`endif
         end
`ifdef SERIALIZER_PARITY_EN
         PAR: begin
            bit_out_n   = par_n;
            bit_valid_n = 1'b1;
            frame_end_n = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer. u0: MSB first, idle 0.
// u1: LSB first, idle 1. A behavioural overlapping 1011 detector watches u0.
module tb_seq_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din, din1;
   logic       din_valid, din_valid1, bit_en;
   logic       din_ready0, bit_out0, bit_valid0, frame_start0, frame_end0, busy0;
   logic       din_ready1, bit_out1, bit_valid1, frame_start1, frame_end1, busy1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
      .bit_en(bit_en), .bit_out(bit_out0), .bit_valid(bit_valid0),
      .frame_start(frame_start0), .frame_end(frame_end0), .busy(busy0));

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
      .bit_en(bit_en), .bit_out(bit_out1), .bit_valid(bit_valid1),
      .frame_start(frame_start1), .frame_end(frame_end1), .busy(busy1));

   // Overlapping 1011 detector on u0's valid, enabled bits.
   logic [2:0] hist;
   int nbits = 0, ndet = 0, last_pos = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) hist <= 3'b000;
      else if (bit_valid0 && bit_en) begin
         nbits <= nbits + 1;
         if ({hist, bit_out0} == 4'b1011) begin
            ndet     <= ndet + 1;
            last_pos <= nbits + 1;
         end
         hist <= {hist[1:0], bit_out0};
      end
   end

   task automatic load0(input logic [7:0] w);
      din = w; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; din = '0; din1 = '0; din_valid = 0; din_valid1 = 0; bit_en = 0;
      #3;
      checks++;
      if ({bit_out0, bit_valid0, frame_start0, frame_end0, busy0, din_ready0} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_u0: got %b want 000001",
                  {bit_out0, bit_valid0, frame_start0, frame_end0, busy0, din_ready0});
      end
      checks++;
      if ({bit_out1, bit_valid1, busy1} !== 3'b100) begin
         errors++;
         $display("FAIL reset_u1: got %b want 100", {bit_out1, bit_valid1, busy1});
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      logic [7:0] w = 8'hB0;
      logic [4:0] exp;
      int sb, sd;
      bit_en = 1'b1; sb = nbits; sd = ndet;
      load0(w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp = {w[7-i], 1'b1, i == 0, (i == 7) && (PEN == 0), (i == 7) && (PEN == 0)};
         checks++;
         if ({bit_out0, bit_valid0, frame_start0, frame_end0, din_ready0} !== exp) begin
            errors++;
            $display("FAIL single_bit%0d: got %b want %b", i,
                     {bit_out0, bit_valid0, frame_start0, frame_end0, din_ready0}, exp);
         end
         @(posedge clk); #1;
      end
`ifdef SERIALIZER_PARITY_EN
      @(negedge clk);
      checks++;
      if ({bit_out0, bit_valid0, frame_start0, frame_end0, din_ready0} !== 5'b11011) begin
         errors++;
         $display("FAIL single_parity: got %b want 11011",
                  {bit_out0, bit_valid0, frame_start0, frame_end0, din_ready0});
      end
      @(posedge clk); #1;
`endif
      @(negedge clk);
      checks++;
      if ({bit_out0, bit_valid0, busy0} !== 3'b000) begin
         errors++;
         $display("FAIL single_idle: got %b want 000", {bit_out0, bit_valid0, busy0});
      end
      checks++;
      if (ndet - sd !== 1 || last_pos - sb !== 4) begin
         errors++;
         $display("FAIL single_detect: got count %0d pos %0d want 1 4", ndet - sd, last_pos - sb);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [17:0] st;
      logic [3:0]  exp;
      int len, hs, sb, sd;
`ifdef SERIALIZER_PARITY_EN
      st = {8'h01, 1'b1, 8'h60, 1'b0}; len = 18; hs = 8;
`else
      st = {2'b00, 8'h01, 8'h60};      len = 16; hs = 7;
`endif
      sb = nbits; sd = ndet;
      bit_en = 1'b1; din = 8'h01; din_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready0: got %b want 1", din_ready0);
      end
      @(posedge clk); #1;
      din = 8'h60;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         exp = {st[len-1-i], 1'b1, (i == 0) || (i == hs + 1), (i == hs) || (i == len - 1)};
         checks++;
         if ({bit_out0, bit_valid0, frame_start0, frame_end0} !== exp) begin
            errors++;
            $display("FAIL b2b_bit%0d: got %b want %b", i,
                     {bit_out0, bit_valid0, frame_start0, frame_end0}, exp);
         end
         if (i < len - 1) begin
            checks++;
            if (din_ready0 !== (i == hs)) begin
               errors++;
               $display("FAIL b2b_ready%0d: got %b want %b", i, din_ready0, i == hs);
            end
         end
         @(posedge clk); #1;
         if (i == hs) din_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({bit_valid0, busy0} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle: got %b want 00", {bit_valid0, busy0});
      end
      checks++;
      if (ndet - sd !== 1 || last_pos - sb !== 11 + PEN) begin
         errors++;
         $display("FAIL b2b_detect: got count %0d pos %0d want 1 %0d",
                  ndet - sd, last_pos - sb, 11 + PEN);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      logic [7:0] w = 8'hB0;
      bit_en = 1'b1;
      load0(w);
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            bit_en = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               checks++;
               if ({bit_out0, bit_valid0, frame_start0} !== 3'b010) begin
                  errors++;
                  $display("FAIL stall_hold%0d: got %b want 010", s,
                           {bit_out0, bit_valid0, frame_start0});
               end
               @(posedge clk); #1;
            end
            bit_en = 1'b1;
         end
         @(negedge clk);
         checks++;
         if ({bit_out0, bit_valid0} !== {w[7-i], 1'b1}) begin
            errors++;
            $display("FAIL stall_bit%0d: got %b want %b", i, {bit_out0, bit_valid0}, {w[7-i], 1'b1});
         end
         @(posedge clk); #1;
      end
`ifdef SERIALIZER_PARITY_EN
      @(posedge clk); #1;
`endif
      @(negedge clk);
      checks++;
      if ({bit_valid0, busy0} !== 2'b00) begin
         errors++;
         $display("FAIL stall_idle: got %b want 00", {bit_valid0, busy0});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lsb_idle;
      logic [7:0] w = 8'h0D;
      logic [7:0] exp_seq = 8'b10110000;
      bit_en = 1'b1;
      @(negedge clk);
      checks++;
      if ({bit_out1, bit_valid1} !== 2'b10) begin
         errors++;
         $display("FAIL lsb_pre_idle: got %b want 10", {bit_out1, bit_valid1});
      end
      @(posedge clk); #1;
      din1 = w; din_valid1 = 1'b1;
      @(posedge clk); #1;
      din_valid1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if ({bit_out1, bit_valid1, frame_start1} !== {exp_seq[7-i], 1'b1, i == 0}) begin
            errors++;
            $display("FAIL lsb_bit%0d: got %b want %b", i,
                     {bit_out1, bit_valid1, frame_start1}, {exp_seq[7-i], 1'b1, i == 0});
         end
         @(posedge clk); #1;
      end
`ifdef SERIALIZER_PARITY_EN
      @(negedge clk);
      checks++;
      if ({bit_out1, bit_valid1, frame_end1} !== 3'b111) begin
         errors++;
         $display("FAIL lsb_parity: got %b want 111", {bit_out1, bit_valid1, frame_end1});
      end
      @(posedge clk); #1;
`endif
      @(negedge clk);
      checks++;
      if ({bit_out1, bit_valid1, busy1} !== 3'b100) begin
         errors++;
         $display("FAIL lsb_post_idle: got %b want 100", {bit_out1, bit_valid1, busy1});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [7:0] w = 8'hB0;
      int sb, sd;
      bit_en = 1'b1;
      load0(w);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({bit_out0, bit_valid0, busy0, frame_start0, frame_end0} !== 5'b00000) begin
         errors++;
         $display("FAIL rstmid_async: got %b want 00000",
                  {bit_out0, bit_valid0, busy0, frame_start0, frame_end0});
      end
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      sb = nbits; sd = ndet;
      load0(w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if ({bit_out0, bit_valid0, frame_start0} !== {w[7-i], 1'b1, i == 0}) begin
            errors++;
            $display("FAIL rstmid_bit%0d: got %b want %b", i,
                     {bit_out0, bit_valid0, frame_start0}, {w[7-i], 1'b1, i == 0});
         end
         @(posedge clk); #1;
      end
      checks++;
      if (ndet - sd !== 1 || last_pos - sb !== 4) begin
         errors++;
         $display("FAIL rstmid_detect: got count %0d pos %0d want 1 4", ndet - sd, last_pos - sb);
      end
      repeat (2) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_lsb_idle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end feeding the bit-stream sequence detectors (1011 Mealy family) through their single-bit `in` port.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled clock.
- Supports back-to-back words with no idle gap, so detector patterns can span word boundaries.
- Drives a defined idle level when it has no data, because the detectors sample `in` every clock and have no valid input.

Parameters:
- WIDTH, 8: data word width in bits, ≥2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- IDLE_LEVEL, 0: value driven on bit_out whenever bit_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word.
- din_ready  output  1  serializer accepts the word this cycle (combinational).
- bit_en  input  1  pacing strobe; the serializer advances one bit only when this is 1.
- bit_out  output  1  serial bit; connects to the detector's `in`.
- bit_valid  output  1  bit_out carries data.
- frame_start  output  1  high while the first bit of a word is on bit_out.
- frame_end  output  1  high while the last bit of a frame is on bit_out.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; bit_out=IDLE_LEVEL; bit_valid=0; frame_start=0; frame_end=0; counter=0; shift register=0.
- Reset asserted mid-frame aborts the frame immediately. The partial word is discarded.
- Handshake: transfer occurs at a rising edge where din_valid && din_ready.
- din_ready = (state==IDLE) || (state==SHIFT && last data bit on output && bit_en && no parity stage pending).
- din_valid may drop without a transfer. din is sampled only at the transfer edge.
- States:
  - IDLE: bit_valid=0, bit_out=IDLE_LEVEL. On transfer: load shift register, go to SHIFT, counter=0.
  - SHIFT: bit_valid=1.
    - bit_out = shift[WIDTH-1] if MSB_FIRST, else shift[0].
    - When bit_en=1: shift by one and counter+1.
    - When bit_en=0: all state and outputs hold. Stalls of any length are legal.
    - After the last data bit with bit_en=1:
      - if a transfer occurs in that cycle, reload and stay in SHIFT with counter=0 (zero-gap back-to-back);
      - else if the parity stage is enabled, go to PAR;
      - else go to IDLE.
- Latency: first bit appears on bit_out the cycle after the transfer edge. Each bit stays on bit_out for exactly one bit_en=1 cycle.
- Frame of WIDTH bits occupies WIDTH enabled cycles.
- Outputs bit_out, bit_valid, frame_start and frame_end are registered. No combinational path from din to bit_out.
- Flags:
  - frame_start=1 when counter==0 in SHIFT.
  - frame_end=1 on the final bit: counter==WIDTH-1 without parity, or in PAR with parity.
- Counter width: $clog2(WIDTH). It never exceeds WIDTH-1.
- Boundary: din_valid held high while busy is ignored until din_ready rises. No word is lost or duplicated.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - Adds state PAR, entered after the last data bit.
  - Emits one even-parity bit (XOR of the word) for one bit_en cycle, with bit_valid=1 and frame_end=1.
  - din_ready stays 0 during the last data bit and rises in PAR when bit_en=1.
  - Frame length is WIDTH+1.
- Undefined: no PAR state; frame length is WIDTH; behaviour exactly as above.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst asynchronously between clock edges during SHIFT.
  - Required: bit_valid=0, bit_out=IDLE_LEVEL, busy=0 immediately, without waiting for a clock edge.
  - Required: the next transfer restarts at bit 0.
- Single word, MSB_FIRST=1, bit_en=1:
  - Stimulus: din=8'hB0.
  - Required: bit_out=1,0,1,1,0,0,0,0 on cycles 1..8; frame_start on cycle 1, frame_end on cycle 8.
  - Required: a downstream 1011 detector asserts out once, after bit 4.
- Back-to-back, MSB_FIRST=1:
  - Stimulus: din_valid held high; words 8'h01 then 8'h60.
  - Required: 16 contiguous valid bits 0000000101100000, with no gap between words.
  - Required: din_ready pulses on cycle 0 and cycle 8 only.
  - Required: the detector sees 1011 across the word boundary.
- Stall:
  - Stimulus: din=8'hB0; bit_en low for 3 cycles after bit 2.
  - Required: bit_out holds 0 and bit_valid=1 during the stall; the sequence then resumes with no bit skipped or repeated.
- LSB_FIRST and idle level:
  - Stimulus: MSB_FIRST=0, IDLE_LEVEL=1, din=8'h0D.
  - Required: bit_out=1,0,1,1,0,0,0,0.
  - Required: bit_out=1 with bit_valid=0 before and after the frame.
- SERIALIZER_PARITY_EN defined:
  - Stimulus: din=8'hB0.
  - Required: 9th bit =1 with frame_end=1; din_ready stays 0 until that parity cycle.
